// File: rtl/coin_acceptor_if.sv
// Coin acceptor port bundle: raw sensor/hold inputs and registered coin-code outputs.
interface coin_acceptor_if #(
  parameter int DEPTH = 4
);
  logic [2:0]              coin_in;
  logic                    hold;
  logic [1:0]              amt;
  logic                    reject;
  logic                    full;
  logic [$clog2(DEPTH):0]  pending;

  modport master (
    output coin_in, hold,
    input  amt, reject, full, pending
  );

  modport slave (
    input  coin_in, hold,
    output amt, reject, full, pending
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: per-channel debounce, rising-edge coin events, coin FIFO, amt code output.
// Optional COIN_ACCEPTOR_SYNC_EN adds a 2-flop synchronizer on each coin_in bit.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4
) (
  input logic            clk,
  input logic            rst,
  coin_acceptor_if.slave bus
);
  localparam int        AW      = $clog2(DEPTH);
  localparam int        PW      = $clog2(DEPTH) + 1;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  function automatic logic [1:0] coin_code(input logic [2:0] ev);
    case (ev)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  logic [2:0]    sample_p0;
  logic [7:0]    cnt_p1 [3];
  logic [2:0]    level_p1;
  logic [2:0]    level_p2;
  logic [2:0]    rise_p2;
  logic          multi_p2;
  logic          single_p2;
  logic          push_p2;
  logic          pop_p2;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  logic          full_r;
  logic [1:0]    amt_r;
  logic          reject_r;

  // Stage p0: sensor sample, optionally synchronized
`ifdef COIN_ACCEPTOR_SYNC_EN
  logic [2:0] meta_p0;
  logic [2:0] sync_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= '0;
      sync_p0 <= '0;
    end else begin
      meta_p0 <= bus.coin_in;
      sync_p0 <= meta_p0;
    end
  end

  assign sample_p0 = sync_p0;
`else
  assign sample_p0 = bus.coin_in;
`endif

  // Stage p1: debounced stable level; p2 keeps the previous level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt_p1[i] <= '0;
      level_p1 <= '0;
      level_p2 <= '0;
    end else begin
      level_p2 <= level_p1;
      for (int i = 0; i < 3; i++) begin
        if (sample_p0[i] == level_p1[i]) begin
          cnt_p1[i] <= '0;
        end else if (cnt_p1[i] == DB_LAST) begin
          level_p1[i] <= sample_p0[i];
          cnt_p1[i]   <= '0;
        end else begin
          cnt_p1[i] <= cnt_p1[i] + 8'd1;
        end
      end
    end
  end

  // Stage p2: event resolution and FIFO push/pop decisions
  assign rise_p2    = level_p1 & ~level_p2;
  assign multi_p2   = (rise_p2 & (rise_p2 - 3'd1)) != 3'd0;
  assign single_p2  = (rise_p2 != 3'd0) && !multi_p2;
  // Fullness is the registered pre-pop value, so a full FIFO never accepts a push-through.
  assign push_p2    = single_p2 && !full_r;
  assign pop_p2     = (count != '0) && !bus.hold;
  assign count_next = count + PW'(push_p2) - PW'(pop_p2);

  always_ff @(posedge clk) begin
    if (push_p2) mem[wr_ptr] <= coin_code(rise_p2);
  end

  // Stage p3: registered outputs and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_r   <= 1'b0;
      amt_r    <= 2'd3;
      reject_r <= 1'b0;
    end else begin
      if (push_p2) wr_ptr <= wr_ptr + AW'(1);
      if (pop_p2)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      full_r   <= (count_next == PW'(DEPTH));
      amt_r    <= pop_p2 ? mem[rd_ptr] : 2'd3;
      reject_r <= multi_p2 || (single_p2 && full_r);
    end
  end

  assign bus.amt     = amt_r;
  assign bus.reject  = reject_r;
  assign bus.full    = full_r;
  assign bus.pending = count;
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage of the coffee vending datapath: it conditions the three raw coin-sensor lines and produces the 2-bit `amt` coin code the vending FSM consumes. Each sensor is debounced, and each clean rising edge becomes one coin event. Events are queued in a small FIFO and emitted one code per cycle. When no coin is presented, the output idles at code 3, which the vending FSM ignores.

## Interface
- `DEBOUNCE`, default 4: consecutive differing samples required to flip a channel's stable level; legal range 2..255.
- `DEPTH`, default 4: coin FIFO entries; power of two, ≥2.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `coin_in`  in  3  — raw sensors, active high: bit0 = 5, bit1 = 10, bit2 = 20.
- `hold`  in  1  — 1 = do not pop the FIFO this cycle (downstream busy).
- `amt`  out  2  — registered coin code: 0 = 5, 1 = 10, 2 = 20, 3 = idle.
- `reject`  out  1  — registered one-cycle pulse: a coin was refused (return-chute gate).
- `full`  out  1  — FIFO holds `DEPTH` entries.
- `pending`  out  $clog2(DEPTH)+1  — current FIFO occupancy.

## Operation
- Reset (`rst`=1 at an edge) clears the following:
  - all debounce counters and stable levels (to 0);
  - FIFO pointers and occupancy;
  - outputs: `amt`=3, `reject`=0, `full`=0, `pending`=0.
- Reset applied mid-operation discards queued coins and any partial debounce.
- Debounce runs independently per channel, with sample `s`, stable level `q` and counter `c`:
  - `s`==`q` → `c`<=0.
  - `s`!=`q` and `c`==`DEBOUNCE`-1 → `q`<=`s`, `c`<=0.
  - Otherwise `c`<=`c`+1.
  - Any glitch shorter than `DEBOUNCE` samples is fully absorbed.
- A coin event on a channel is that channel's `q` rising (0→1). Falling edges generate nothing.
- Event resolution, evaluated per cycle:
  - Exactly one channel has an event and the FIFO is not full → push its code (5→0, 10→1, 20→2).
  - Two or more simultaneous events → push nothing and pulse `reject` (ambiguous coin).
  - One event while `full`=1 → drop it and pulse `reject`. Fullness is judged before this cycle's pop: no push-through on full.
- Output stage, per cycle:
  - FIFO non-empty and `hold`=0 → `amt`<=head code and pop.
  - Otherwise → `amt`<=3.
  - Each entry therefore appears on `amt` for exactly one cycle. Back-to-back entries appear on consecutive cycles.
- Empty FIFO with a push: no bypass. The entry is stored and emitted at the next eligible cycle.
- Push and pop in the same cycle with 0 < occupancy < `DEPTH` → occupancy unchanged.
- FIFO pointers wrap modulo `DEPTH`. `pending` saturates at neither end; overflow and underflow are impossible by construction.

## Timing
- Without the synchronizer, `coin_in` rises before edge t0 and stays high:
  - `q` flips at edge t0+`DEBOUNCE`-1;
  - the push occurs at edge t0+`DEBOUNCE`;
  - `amt` shows the code after edge t0+`DEBOUNCE`+1 (FIFO empty, `hold`=0).
- `reject` is asserted after edge t0+`DEBOUNCE` for exactly one cycle.
- `full` and `pending` are registered and reflect the state after each edge.
- `hold` is sampled at the same edge as the pop decision. A `hold` asserted in cycle n suppresses the pop at edge n.
- Minimum coin spacing per channel: 2×`DEBOUNCE` cycles (high plus low debounce).

## Configuration
- `COIN_ACCEPTOR_SYNC_EN` defined: each `coin_in` bit passes through a 2-flop synchronizer (reset to 0) before debounce. All latencies above increase by 2 cycles.
- `COIN_ACCEPTOR_SYNC_EN` undefined: `coin_in` feeds the debounce sample directly. The input must then already be synchronous to `clk`.

## Test plan
- Reset check: `rst`=1 for 2 cycles with `coin_in`=3'b111 → `amt`=3, `reject`=0, `pending`=0 throughout and 1 cycle after release.
- Clean coin, `DEBOUNCE`=4, sync off: `coin_in`[1] high for 10 cycles from t0 → `amt`=1 for exactly one cycle after edge t0+5, otherwise 3.
- Glitch: `coin_in`[0] high for 3 cycles, then low → no push, `amt` stays 3, `reject`=0.
- Simultaneous: bits 0 and 2 rise together and hold 10 cycles → one `reject` pulse after edge t0+4, no push.
- Overflow with `hold`=1: five 20-coins, `DEPTH`=4 → `pending`=4, `full`=1, fifth coin pulses `reject`. Release `hold` → `amt`=2 for 4 consecutive cycles, then 3, `pending`=0.
- Mid-operation reset: 3 coins queued, pulse `rst` one cycle → `pending`=0, `amt`=3, no stale codes afterward. Repeat with `COIN_ACCEPTOR_SYNC_EN` defined → clean-coin latency is t0+7.
